// File: rtl/fec_serial_rx.sv
// -----------------------------------------------------------------------------
// fec_serial_rx
//
// Serial line receiver for the FEC link. Recovers framed code words from an
// asynchronous single-bit line and hands each good word to the FEC decoder
// as a one-cycle valid pulse.
//
// Frame: start bit (0), CODE_W data bits LSB first, optional even-parity bit,
// stop bit (1). Every bit is sampled mid-bit, a whole number of bit periods
// after the start-bit sample.
//
// Optional feature macro: FEC_SERIAL_RX_PARITY_EN
//   defined     : frame carries an even-parity bit; mismatch pulses err_parity
//   not defined : no parity bit, err_parity tied to 0
//
// Parameters:
//   CODE_W      code word width in bits (>= 2)
//   BIT_CYCLES  clock cycles per serial bit (even, >= 4)
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          block enable; 0 forces IDLE and clears the frame state
//   rx          serial line, asynchronous to clk, idles high
//   ack         one-cycle pulse: data_out holds a new good code word
//   data_out    last good code word, held between pulses
//   err_frame   one-cycle pulse: stop bit sampled as 0
//   err_parity  one-cycle pulse: parity mismatch (parity build only)
//   busy        high while the FSM is not in IDLE
// -----------------------------------------------------------------------------
module fec_serial_rx #(
  parameter int CODE_W     = 13,
  parameter int BIT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              rx,
  output logic              ack,
  output logic [CODE_W-1:0] data_out,
  output logic              err_frame,
  output logic              err_parity,
  output logic              busy
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CODE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef FEC_SERIAL_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Both flops reset to the idle level. sync_fill marks
  // when rx_s carries a real line value rather than the reset value, so a
  // line held low through reset is never mistaken for a fresh start bit.
  // ---------------------------------------------------------------------------
  logic       rx_meta;
  logic       rx_s;
  logic [1:0] sync_fill;

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of its neighbours, exactly as the hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t             state,    state_n;
  logic [CNT_W-1:0]   cnt,      cnt_n;
  logic [IDX_W-1:0]   bit_idx,  bit_idx_n;
  logic [CODE_W-1:0]  shreg,    shreg_n;
  logic [CODE_W-1:0]  data_n;
  logic               armed,    armed_n;   // line seen high since last frame
  logic               ack_n;
  logic               err_frame_n;
`ifdef FEC_SERIAL_RX_PARITY_EN
  logic               par_bit,  par_bit_n;
  logic               err_parity_q, err_parity_n;
`endif

  // NOTE: every variable gets its default before the case statement, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    data_n      = data_out;
    armed_n     = armed;
    ack_n       = 1'b0;
    err_frame_n = 1'b0;
`ifdef FEC_SERIAL_RX_PARITY_EN
    par_bit_n    = par_bit;
    err_parity_n = 1'b0;
`endif

    if (!en) begin
      // Disabled: abandon any frame and require the line to go high again
      // before the next start bit is accepted.
      state_n   = S_IDLE;
      cnt_n     = '0;
      bit_idx_n = '0;
      shreg_n   = '0;
      armed_n   = 1'b0;
`ifdef FEC_SERIAL_RX_PARITY_EN
      par_bit_n = 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_s) begin
            if (sync_fill[1]) armed_n = 1'b1;
          end else if (armed) begin
            state_n = S_START;
            cnt_n   = '0;
            armed_n = 1'b0;
          end
        end

        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt_n = '0;
            if (rx_s) begin
              // Line went back high before mid start bit: glitch.
              state_n = S_IDLE;
              armed_n = 1'b1;
            end else begin
              state_n   = S_DATA;
              bit_idx_n = '0;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt_n   = '0;
            shreg_n = {rx_s, shreg[CODE_W-1:1]};
            if (bit_idx == IDX_LAST) begin
              bit_idx_n = '0;
`ifdef FEC_SERIAL_RX_PARITY_EN
              state_n   = S_PARITY;
`else
              state_n   = S_STOP;
`endif
            end else begin
              bit_idx_n = bit_idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end

`ifdef FEC_SERIAL_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt_n     = '0;
            par_bit_n = rx_s;
            state_n   = S_STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt_n   = '0;
            state_n = S_IDLE;
            // A low stop bit leaves the block disarmed until the line idles,
            // so a stuck-low line produces one framing error and then waits.
            armed_n = rx_s;
            if (!rx_s) begin
              err_frame_n = 1'b1;
`ifdef FEC_SERIAL_RX_PARITY_EN
            end else if ((^shreg) != par_bit) begin
              err_parity_n = 1'b1;
`endif
            end else begin
              ack_n  = 1'b1;
              data_n = shreg;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end

        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      armed     <= 1'b0;
      ack       <= 1'b0;
      err_frame <= 1'b0;
`ifdef FEC_SERIAL_RX_PARITY_EN
      par_bit      <= 1'b0;
      err_parity_q <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      data_out  <= data_n;
      armed     <= armed_n;
      ack       <= ack_n;
      err_frame <= err_frame_n;
`ifdef FEC_SERIAL_RX_PARITY_EN
      par_bit      <= par_bit_n;
      err_parity_q <= err_parity_n;
`endif
    end
  end

`ifdef FEC_SERIAL_RX_PARITY_EN
  assign err_parity = err_parity_q;
`else
  assign err_parity = 1'b0;
`endif

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_fec_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_fec_serial_rx
//
// Self-checking bench for fec_serial_rx. Frames are built as bit lists and
// driven onto rx; a frame-level model predicts, for every frame, which pulse
// appears, on which cycle, and what data_out shows at that moment. A monitor
// records every pulse the DUT produces and the two lists are compared.
// Honours FEC_SERIAL_RX_PARITY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fec_serial_rx;

  localparam int CODE_W = 13;
  localparam int BC     = 16;
`ifdef FEC_SERIAL_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS = CODE_W + 2 + (PAR_EN ? 1 : 0);
  // rx falling edge -> pulse: 2 sync + half bit + remaining bits + output edge
  localparam int LAT   = 2 + BC / 2 + (NBITS - 1) * BC + 1;

  localparam int K_ACK = 0;
  localparam int K_FRM = 1;
  localparam int K_PAR = 2;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              en    = 1'b0;
  logic              rx    = 1'b1;
  logic              ack;
  logic [CODE_W-1:0] data_out;
  logic              err_frame;
  logic              err_parity;
  logic              busy;

  fec_serial_rx #(.CODE_W(CODE_W), .BIT_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rx         (rx),
    .ack        (ack),
    .data_out   (data_out),
    .err_frame  (err_frame),
    .err_parity (err_parity),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                kind;
    logic [CODE_W-1:0] data;
    int                cyc;
  } ev_t;

  ev_t               obs_q[$];
  ev_t               exp_q[$];
  logic [CODE_W-1:0] exp_data = '0;
  int                n_checks = 0;
  int                n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic ev_t mk_ev(int kind, logic [CODE_W-1:0] data, int at);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = at;
    return e;
  endfunction

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (ack)        obs_q.push_back(mk_ev(K_ACK, data_out, cyc));
    if (err_frame)  obs_q.push_back(mk_ev(K_FRM, data_out, cyc));
    if (err_parity) obs_q.push_back(mk_ev(K_PAR, data_out, cyc));
  end

  // Frame-level reference: outcome depends only on stop bit and parity.
  function automatic void expect_frame(logic [CODE_W-1:0] word, logic par_flip,
                                       logic stop_bit, int at);
    if (!stop_bit) begin
      exp_q.push_back(mk_ev(K_FRM, exp_data, at));
    end else if (PAR_EN && par_flip) begin
      exp_q.push_back(mk_ev(K_PAR, exp_data, at));
    end else begin
      exp_data = word;
      exp_q.push_back(mk_ev(K_ACK, word, at));
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; called and returns 1 time unit after a rising edge.
  task automatic send_frame(input logic [CODE_W-1:0] word, input logic par_flip,
                            input logic stop_bit, input bit chk_busy, input bit lost);
    logic bits[$];
    int   t0;
    bits.push_back(1'b0);
    for (int i = 0; i < CODE_W; i++) bits.push_back(word[i]);
    if (PAR_EN) bits.push_back((^word) ^ par_flip);
    bits.push_back(stop_bit);
    t0 = cyc;
    if (!lost) expect_frame(word, par_flip, stop_bit, t0 + LAT);
    foreach (bits[k]) begin
      rx = bits[k];
      for (int c = 0; c < BC; c++) begin
        if (chk_busy && c == BC / 2) check("busy_in_frame", 32'(busy), 32'd1);
        tick();
      end
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    repeat (2 * BC) tick();
    check({tag, "_n_events"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_kind"}, 32'(obs_q[i].kind), 32'(exp_q[i].kind));
      check({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
      check({tag, "_cycle"}, 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
    end
    check({tag, "_data_out"}, 32'(data_out), 32'(exp_data));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int                t0;
    int                gap;
    logic [CODE_W-1:0] word;
    logic              stop;
    logic              pf;

    // Reset state
    repeat (3) tick();
    check("rst_ack",        32'(ack),        32'd0);
    check("rst_data_out",   32'(data_out),   32'd0);
    check("rst_err_frame",  32'(err_frame),  32'd0);
    check("rst_err_parity", 32'(err_parity), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (4) tick();

    // Directed good frame, busy checked in every bit
    send_frame(13'h1A5B, 1'b0, 1'b1, 1'b1, 1'b0);
    rx = 1'b1;
    compare_events("good");

    // Glitch: low for 3 cycles, then high
    t0 = cyc;
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (2) tick();
    check("glitch_busy_hi", 32'(busy), 32'd1);
    repeat (t0 + 11 - cyc) tick();
    check("glitch_busy_lo", 32'(busy), 32'd0);
    compare_events("glitch");
    send_frame(13'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    compare_events("after_glitch");

    // Framing error
    send_frame(13'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    compare_events("frame_err");

    // Back-to-back frames
    send_frame(13'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(13'h1FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(13'h0AAA, 1'b0, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    compare_events("b2b");

`ifdef FEC_SERIAL_RX_PARITY_EN
    send_frame(13'h0007, 1'b0, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    compare_events("parity_good");
    send_frame(13'h0007, 1'b1, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    compare_events("parity_bad");
`endif

    // Enable dropped for one cycle mid-DATA; rest of the frame must be ignored
    fork
      send_frame(13'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
      begin
        repeat (5 * BC + 3) tick();
        en = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        en = 1'b1;
      end
    join
    rx = 1'b1;
    compare_events("abort");
    send_frame(13'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    compare_events("after_abort");

    // Reset asserted mid-frame: outputs clear at once
    fork
      send_frame(13'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
      begin
        repeat (100) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ack",        32'(ack),        32'd0);
        check("midrst_data_out",   32'(data_out),   32'd0);
        check("midrst_err_frame",  32'(err_frame),  32'd0);
        check("midrst_err_parity", 32'(err_parity), 32'd0);
        check("midrst_busy",       32'(busy),       32'd0);
        exp_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
      end
    join
    rx = 1'b1;
    compare_events("reset");
    send_frame(13'h15A3, 1'b0, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    compare_events("after_reset");

    // Line stuck low: one framing error, then quiet until the line idles
    t0 = cyc;
    rx = 1'b0;
    exp_q.push_back(mk_ev(K_FRM, exp_data, t0 + LAT));
    repeat (LAT + 3 * BC) tick();
    check("stuck_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    compare_events("stuck");
    send_frame(13'h0B6D, 1'b0, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    compare_events("after_stuck");

    // Randomized frames, random gaps (0 = back-to-back), some bad stop/parity
    for (int i = 0; i < 20; i++) begin
      word = CODE_W'($urandom);
      stop = ($urandom_range(5) != 0);
      pf   = PAR_EN && ($urandom_range(3) == 0);
      send_frame(word, pf, stop, 1'b0, 1'b0);
      gap = $urandom_range(12);
      if (!stop && gap < 3) gap = 3;
      if (gap > 0) begin
        rx = 1'b1;
        repeat (gap) tick();
      end
    end
    rx = 1'b1;
    compare_events("random");

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
